cdb_broadcaster: RTL



---
 rtl/cdb_broadcaster_if.sv | 26 ++
 rtl/cdb_broadcaster.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster_if.sv
// Bundle between the functional units and the CDB broadcaster.
// The master side is the FU/listener side; the slave side is the broadcaster.
interface cdb_broadcaster_if #(
  parameter int NFU  = 4,
  parameter int TAGW = 3,
  parameter int DW   = 16
);
  logic [NFU-1:0]      fu_push;
  logic [NFU*TAGW-1:0] fu_tag;
  logic [NFU*DW-1:0]   fu_data;
  logic [NFU-1:0]      fu_full;
  logic                cdb_valid;
  logic [TAGW-1:0]     cdb_tag;
  logic [DW-1:0]       cdb_data;
  logic [2:0]          cdb_src;

  modport master (
    output fu_push, fu_tag, fu_data,
    input  fu_full, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  fu_push, fu_tag, fu_data,
    output fu_full, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one holding slot per functional unit, round-robin grant,
// registered broadcast of {tag, data, src}.

module cdb_slot #(
  parameter int TAGW = 3,
  parameter int DW   = 16
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            push,
  input  logic            grant,
  input  logic [TAGW-1:0] tag_in,
  input  logic [DW-1:0]   data_in,
  output logic            full,
  output logic [TAGW-1:0] tag,
  output logic [DW-1:0]   data
);
  // Tag 0 means "no dependency" and is never held; a push into an occupied
  // slot is dropped even if that slot is being granted this cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      full <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (grant) begin
      full <= 1'b0;
    end else if (push && !full && (tag_in != '0)) begin
      full <= 1'b1;
      tag  <= tag_in;
      data <= data_in;
    end
  end
endmodule

module cdb_broadcaster #(
  parameter int NFU  = 4,
  parameter int TAGW = 3,
  parameter int DW   = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  cdb_broadcaster_if.slave  bus
);
  localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

  logic [NFU-1:0]           full;
  logic [NFU-1:0]           grant;
  logic [NFU-1:0][TAGW-1:0] stag;
  logic [NFU-1:0][DW-1:0]   sdata;

  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            gnt_idx;
  logic                     gnt_vld;
  logic [PW:0]              cand;

  logic                     cdb_valid_q;
  logic [TAGW-1:0]          cdb_tag_q;
  logic [DW-1:0]            cdb_data_q;
  logic [2:0]               cdb_src_q;

  for (genvar i = 0; i < NFU; i++) begin : g_slot
    cdb_slot #(.TAGW(TAGW), .DW(DW)) u_slot (
      .CLK     (CLK),
      .CLR     (CLR),
      .push    (bus.fu_push[i]),
      .grant   (grant[i]),
      .tag_in  (bus.fu_tag[i*TAGW +: TAGW]),
      .data_in (bus.fu_data[i*DW +: DW]),
      .full    (full[i]),
      .tag     (stag[i]),
      .data    (sdata[i])
    );
  end

  // Search rr_ptr, rr_ptr+1, ... modulo NFU; first occupied slot wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NFU; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NFU)) cand = cand - (PW+1)'(NFU);
      if (!gnt_vld && full[cand[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (gnt_vld) begin
      rr_ptr      <= (gnt_idx == PW'(NFU-1)) ? '0 : gnt_idx + 1'b1;
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= stag[gnt_idx];
      cdb_data_q  <= sdata[gnt_idx];
      cdb_src_q   <= 3'(gnt_idx);
    end else begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end
  end

  assign bus.fu_full   = full;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule
